// File: rtl/mem_arbiter_fill_pkg.sv
// Shared types and constants for the memory arbiter / block-fill sequencer.
// Address and word widths are fixed by the cache geometry (16-byte blocks of 16-bit words).
package mem_arbiter_fill_pkg;

    localparam int ADDR_W        = 16;
    localparam int DATA_W        = 16;
    localparam int WORDS_PER_BLK = 8;
    localparam int WORD_BYTES    = 2;
    localparam int MEM_LAT       = 4;

    localparam logic [ADDR_W-1:0] BLK_OFFSET_MASK = 16'h000F;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        D_WRITE = 2'd1,
        D_FILL  = 2'd2,
        I_FILL  = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_DWR  = 2'd1,
        GNT_D    = 2'd2,
        GNT_I    = 2'd3
    } gnt_e;

    // Fixed priority: stores first so write-through data never goes stale behind a fill.
    function automatic gnt_e pick_grant(input logic wr_req, input logic d_req, input logic i_req);
        if (wr_req) begin
            return GNT_DWR;
        end else if (d_req) begin
            return GNT_D;
        end else if (i_req) begin
            return GNT_I;
        end
        return GNT_NONE;
    endfunction

    function automatic logic [ADDR_W-1:0] blk_base(input logic [ADDR_W-1:0] addr);
        return addr & ~BLK_OFFSET_MASK;
    endfunction

    // Base has a zero offset field, so OR-ing the word offset can never carry out of the block.
    function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] base, input logic [2:0] idx);
        return base | (ADDR_W'(idx) * ADDR_W'(WORD_BYTES));
    endfunction

endpackage

// File: rtl/mem_arbiter_fill_counter.sv
// Word counter for one block: clear, enable and a flag marking the last word of the block.
module blk_word_counter
    import mem_arbiter_fill_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       en,
    output logic [2:0] count,
    output logic       last
);

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + 3'd1;
        end
    end

    assign last = (count == 3'(WORDS_PER_BLK - 1));

endmodule

// File: rtl/mem_arbiter_fill.sv
// Arbitrates the shared pipelined memory between I-cache fills, D-cache fills and
// write-through stores; issues block reads back to back and streams returned words.
module mem_arbiter_fill
    import mem_arbiter_fill_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_miss,
    input  logic [ADDR_W-1:0] i_miss_addr,
    input  logic              d_miss,
    input  logic [ADDR_W-1:0] d_miss_addr,
    input  logic              d_wr_req,
    input  logic [ADDR_W-1:0] d_wr_addr,
    input  logic [DATA_W-1:0] d_wr_data,
    output logic              mem_enable,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_out,
    input  logic [DATA_W-1:0] mem_data_in,
    input  logic              mem_data_valid,
    output logic [DATA_W-1:0] fill_data,
    output logic [2:0]        fill_word_idx,
    output logic              i_fill_we,
    output logic              d_fill_we,
    output logic              i_fill_done,
    output logic              d_fill_done,
    output logic              d_wr_done,
    output logic              busy
);

    state_e            state;
    gnt_e              gnt;
    logic [ADDR_W-1:0] base_addr;
    logic              fill_state;
    logic              grant_fill;
    logic [2:0]        iss_count;
    logic              iss_last;
    logic              iss_en;
    logic [2:0]        ret_count;
    logic              ret_last;
    logic              ret_en;

    always_comb begin
        gnt = pick_grant(d_wr_req, d_miss, i_miss);
    end

    assign fill_state = (state == D_FILL) || (state == I_FILL);
    assign grant_fill = (state == IDLE) && ((gnt == GNT_D) || (gnt == GNT_I));
    assign iss_en     = fill_state && mem_enable && !iss_last;
    assign ret_en     = fill_state && mem_data_valid;

    blk_word_counter u_iss_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (grant_fill),
        .en    (iss_en),
        .count (iss_count),
        .last  (iss_last)
    );

    blk_word_counter u_ret_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (grant_fill),
        .en    (ret_en),
        .count (ret_count),
        .last  (ret_last)
    );

    // Issue-side outputs are registered alongside the state so they line up with it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            mem_enable   <= 1'b0;
            mem_wr       <= 1'b0;
            mem_addr     <= '0;
            mem_data_out <= '0;
            base_addr    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    case (gnt)
                        GNT_DWR: begin
                            state        <= D_WRITE;
                            mem_enable   <= 1'b1;
                            mem_wr       <= 1'b1;
                            mem_addr     <= d_wr_addr;
                            mem_data_out <= d_wr_data;
                        end
                        GNT_D: begin
                            state      <= D_FILL;
                            mem_enable <= 1'b1;
                            mem_wr     <= 1'b0;
                            base_addr  <= blk_base(d_miss_addr);
                            mem_addr   <= blk_base(d_miss_addr);
                        end
                        GNT_I: begin
                            state      <= I_FILL;
                            mem_enable <= 1'b1;
                            mem_wr     <= 1'b0;
                            base_addr  <= blk_base(i_miss_addr);
                            mem_addr   <= blk_base(i_miss_addr);
                        end
                        default: begin
                            state <= IDLE;
                        end
                    endcase
                end
                D_WRITE: begin
                    state        <= IDLE;
                    mem_enable   <= 1'b0;
                    mem_wr       <= 1'b0;
                    mem_addr     <= '0;
                    mem_data_out <= '0;
                end
                D_FILL, I_FILL: begin
                    if (mem_enable) begin
                        if (iss_last) begin
                            mem_enable <= 1'b0;
                            mem_addr   <= '0;
                        end else begin
                            mem_addr <= word_addr(base_addr, iss_count + 3'd1);
                        end
                    end
                    if (mem_data_valid && ret_last) begin
                        state      <= IDLE;
                        mem_enable <= 1'b0;
                        mem_addr   <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Return side follows mem_data_valid combinationally so words land in the cache the cycle they arrive.
    assign fill_data     = mem_data_in;
    assign fill_word_idx = ret_count;
    assign i_fill_we     = (state == I_FILL) && mem_data_valid;
    assign d_fill_we     = (state == D_FILL) && mem_data_valid;
    assign i_fill_done   = i_fill_we && ret_last;
    assign d_fill_done   = d_fill_we && ret_last;
    assign d_wr_done     = (state == D_WRITE);
    assign busy          = (state != IDLE);

endmodule

// File: tb/tb_mem_arbiter_fill.sv
// Bench for mem_arbiter_fill: pipelined memory model, requester that drops on done,
// table-driven single transactions plus hand-written multi-cycle corner cases.
module tb_mem_arbiter_fill;
  import mem_arbiter_fill_pkg::*;

  localparam int K_WR = 0;
  localparam int K_D  = 1;
  localparam int K_I  = 2;

  // clock / reset block
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic              i_miss = 1'b0;
  logic [ADDR_W-1:0] i_miss_addr = '0;
  logic              d_miss = 1'b0;
  logic [ADDR_W-1:0] d_miss_addr = '0;
  logic              d_wr_req = 1'b0;
  logic [ADDR_W-1:0] d_wr_addr = '0;
  logic [DATA_W-1:0] d_wr_data = '0;
  logic              mem_enable;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data_out;
  logic [DATA_W-1:0] mem_data_in;
  logic              mem_data_valid;
  logic [DATA_W-1:0] fill_data;
  logic [2:0]        fill_word_idx;
  logic              i_fill_we;
  logic              d_fill_we;
  logic              i_fill_done;
  logic              d_fill_done;
  logic              d_wr_done;
  logic              busy;
  logic              inj_valid = 1'b0;

  mem_arbiter_fill dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_miss         (i_miss),
    .i_miss_addr    (i_miss_addr),
    .d_miss         (d_miss),
    .d_miss_addr    (d_miss_addr),
    .d_wr_req       (d_wr_req),
    .d_wr_addr      (d_wr_addr),
    .d_wr_data      (d_wr_data),
    .mem_enable     (mem_enable),
    .mem_wr         (mem_wr),
    .mem_addr       (mem_addr),
    .mem_data_out   (mem_data_out),
    .mem_data_in    (mem_data_in),
    .mem_data_valid (mem_data_valid),
    .fill_data      (fill_data),
    .fill_word_idx  (fill_word_idx),
    .i_fill_we      (i_fill_we),
    .d_fill_we      (d_fill_we),
    .i_fill_done    (i_fill_done),
    .d_fill_done    (d_fill_done),
    .d_wr_done      (d_wr_done),
    .busy           (busy)
  );

  function automatic logic [15:0] mem_val(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h3C96;
  endfunction

  // pipelined memory: read issued in cycle c returns in cycle c+MEM_LAT
  logic [MEM_LAT-1:0] pv = '0;
  logic [15:0]        pd [MEM_LAT];
  always @(posedge clk) begin
    pv <= {pv[MEM_LAT-2:0], mem_enable & ~mem_wr};
    pd[0] <= mem_val(mem_addr);
    for (int i = 1; i < MEM_LAT; i++) pd[i] <= pd[i-1];
  end
  assign mem_data_valid = pv[MEM_LAT-1] | inj_valid;
  assign mem_data_in    = pd[MEM_LAT-1];

  // scoreboard: {cycle, wr, addr, wdata, wr_done} and {cycle, i_we, d_we, idx, data, i_done, d_done}
  logic [65:0] exp_mem_q[$];
  logic [54:0] exp_fill_q[$];
  int n_checks = 0;
  int n_pass = 0;
  int n_we_seen = 0;

  task automatic check(input string name, input logic [65:0] act, input logic [65:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic push_fill(input int t, input logic is_i, input logic [15:0] base);
    logic [15:0] a;
    for (int k = 0; k < WORDS_PER_BLK; k++) begin
      a = base + 16'(2 * k);
      exp_mem_q.push_back({32'(t + 1 + k), 1'b0, a, 16'h0000, 1'b0});
      exp_fill_q.push_back({32'(t + 1 + MEM_LAT + k), is_i, ~is_i, 3'(k), mem_val(a),
                            is_i & (k == 7), ~is_i & (k == 7)});
    end
  endtask

  task automatic push_write(input int t, input logic [15:0] a, input logic [15:0] d);
    exp_mem_q.push_back({32'(t + 1), 1'b1, a, d, 1'b1});
  endtask

  task automatic monitor();
    logic [65:0] act_m;
    logic [54:0] act_f;
    if (mem_enable || d_wr_done) begin
      act_m = {32'(cyc), mem_wr, mem_addr, (mem_wr ? mem_data_out : 16'h0000), d_wr_done};
      if (exp_mem_q.size() == 0) check("mem_unexpected", act_m, 66'd0);
      else check("mem_issue", act_m, exp_mem_q.pop_front());
    end
    if (i_fill_we || d_fill_we || i_fill_done || d_fill_done) begin
      act_f = {32'(cyc), i_fill_we, d_fill_we, fill_word_idx, fill_data, i_fill_done, d_fill_done};
      if (exp_fill_q.size() == 0) check("fill_unexpected", 66'(act_f), 66'd0);
      else check("fill_word", 66'(act_f), 66'(exp_fill_q.pop_front()));
    end
    if (i_fill_we || d_fill_we) n_we_seen++;
  endtask

  // driver: sample at negedge, react (requesters drop on their done pulse) just after
  task automatic run(input int n);
    repeat (n) begin
      @(negedge clk);
      monitor();
      #1;
      if (i_fill_done) i_miss = 1'b0;
      if (d_fill_done) d_miss = 1'b0;
      if (d_wr_done) d_wr_req = 1'b0;
    end
  endtask

  function automatic logic [42:0] all_outs();
    return {mem_enable, mem_wr, mem_addr, mem_data_out, fill_word_idx,
            i_fill_we, d_fill_we, i_fill_done, d_fill_done, d_wr_done, busy};
  endfunction

  typedef struct {
    int          kind;
    logic [15:0] addr;
    logic [15:0] data;
    logic [15:0] exp_addr;
  } vec_t;

  vec_t vecs[8];
  int t;
  int we_before;
  logic [15:0] r_addr;

  initial begin
    r_addr = 16'($urandom_range(0, 65535));
    vecs[0] = '{K_I,  16'h0046, 16'h0000, 16'h0040};
    vecs[1] = '{K_D,  16'h1238, 16'h0000, 16'h1230};
    vecs[2] = '{K_WR, 16'h2002, 16'hBEEF, 16'h2002};
    vecs[3] = '{K_I,  16'hFFFE, 16'h0000, 16'hFFF0};
    vecs[4] = '{K_D,  16'h000F, 16'h0000, 16'h0000};
    vecs[5] = '{K_WR, 16'hFFFF, 16'h1234, 16'hFFFF};
    vecs[6] = '{K_D,  r_addr, 16'h0000, {r_addr[15:4], 4'h0}};
    vecs[7] = '{K_WR, r_addr, 16'(~r_addr), r_addr};

    rst_n = 1'b0;
    run(3);
    check("reset_outputs", 66'(all_outs()), 66'd0);
    rst_n = 1'b1;
    run(2);

    for (int v = 0; v < 8; v++) begin
      t = cyc;
      case (vecs[v].kind)
        K_WR: begin
          d_wr_req = 1'b1; d_wr_addr = vecs[v].addr; d_wr_data = vecs[v].data;
          push_write(t, vecs[v].exp_addr, vecs[v].data);
        end
        K_D: begin
          d_miss = 1'b1; d_miss_addr = vecs[v].addr;
          push_fill(t, 1'b0, vecs[v].exp_addr);
        end
        default: begin
          i_miss = 1'b1; i_miss_addr = vecs[v].addr;
          push_fill(t, 1'b1, vecs[v].exp_addr);
        end
      endcase
      run(16);
      check("idle_after_vec", 66'(busy), 66'd0);
    end

    // D and I miss together: D first, I issues 2 cycles after d_fill_done
    t = cyc;
    d_miss = 1'b1; d_miss_addr = 16'h1238;
    i_miss = 1'b1; i_miss_addr = 16'h0046;
    push_fill(t, 1'b0, 16'h1230);
    push_fill(t + 13, 1'b1, 16'h0040);
    run(30);
    check("idle_after_d_then_i", 66'(busy), 66'd0);

    // store raised on 3rd issue cycle of an I fill waits until after i_fill_done
    t = cyc;
    i_miss = 1'b1; i_miss_addr = 16'h0520;
    push_fill(t, 1'b1, 16'h0520);
    run(3);
    d_wr_req = 1'b1; d_wr_addr = 16'h3004; d_wr_data = 16'hCAFE;
    push_write(t + 13, 16'h3004, 16'hCAFE);
    run(16);
    check("idle_after_wr_wait", 66'(busy), 66'd0);

    // requester drops mid-fill and its address changes: fill still completes from latched base
    t = cyc;
    i_miss = 1'b1; i_miss_addr = 16'h0A16;
    push_fill(t, 1'b1, 16'h0A10);
    run(2);
    i_miss = 1'b0; i_miss_addr = 16'hFFFF;
    run(16);
    check("idle_after_drop", 66'(busy), 66'd0);

    // mem_data_valid in IDLE and in D_WRITE must not produce fill writes
    we_before = n_we_seen;
    inj_valid = 1'b1;
    run(1);
    check("idle_valid_no_we", 66'({i_fill_we, d_fill_we, fill_word_idx}), 66'd0);
    t = cyc;
    d_wr_req = 1'b1; d_wr_addr = 16'h4446; d_wr_data = 16'h0F0F;
    push_write(t, 16'h4446, 16'h0F0F);
    run(1);
    check("dwrite_valid_no_we", 66'({i_fill_we, d_fill_we}), 66'd0);
    inj_valid = 1'b0;
    run(4);
    check("no_we_in_idle_or_write", 66'(n_we_seen - we_before), 66'd0);

    // reset after 3 returned words of a D fill: stale returns are ignored
    t = cyc;
    d_miss = 1'b1; d_miss_addr = 16'h7788;
    for (int k = 0; k < 7; k++)
      exp_mem_q.push_back({32'(t + 1 + k), 1'b0, 16'h7780 + 16'(2 * k), 16'h0000, 1'b0});
    for (int k = 0; k < 3; k++)
      exp_fill_q.push_back({32'(t + 1 + MEM_LAT + k), 1'b0, 1'b1, 3'(k),
                            mem_val(16'h7780 + 16'(2 * k)), 1'b0, 1'b0});
    run(7);
    rst_n = 1'b0; d_miss = 1'b0;
    we_before = n_we_seen;
    run(1);
    check("reset_mid_fill_outputs", 66'(all_outs()), 66'd0);
    rst_n = 1'b1;
    run(8);
    check("no_stale_we", 66'(n_we_seen - we_before), 66'd0);

    check("mem_q_drained", 66'(exp_mem_q.size()), 66'd0);
    check("fill_q_drained", 66'(exp_fill_q.size()), 66'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
